// File: rtl/clock_pkg.sv
// Shared constants for the clock front-end: button indices, button count,
// the default auto-repeat mask, the repeat FSM state type and a ms-to-cycles helper.
package clock_pkg;

   localparam int N_BTN       = 6;

   localparam int BTN_RESET   = 0;
   localparam int BTN_WR      = 1;
   localparam int BTN_VAL_INC = 2;
   localparam int BTN_VAL_DEC = 3;
   localparam int BTN_SEL_INC = 4;
   localparam int BTN_SEL_DEC = 5;

   localparam logic [N_BTN-1:0] RPT_MASK_DEFAULT =
      N_BTN'((1 << BTN_VAL_INC) | (1 << BTN_VAL_DEC));

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_t;

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-buttons and the clock core.
// master drives the raw buttons; slave (the conditioner) returns level, press and ms_tick.
interface button_conditioner_if #(
   parameter int N_BTN = clock_pkg::N_BTN
);
   logic [N_BTN-1:0] btn;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;
   logic             ms_tick;

   modport master (output btn, input level, press, ms_tick);
   modport slave  (input btn, output level, press, ms_tick);
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: registered one-cycle ms_tick every CLK_HZ/1000 cycles,
// first tick CLK_HZ/1000 cycles after reset release; free-running, no backpressure.
module ms_tick_gen
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 12_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic ms_tick
);

   localparam int TERM = ms_to_cycles(CLK_HZ, 1) - 1;
   localparam int W    = (TERM > 0) ? $clog2(TERM + 1) : 1;

   logic [W-1:0] cnt;
   logic         at_term;

   assign at_term = (cnt == W'(TERM));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         ms_tick <= 1'b0;
      end else begin
         ms_tick <= at_term;
         cnt     <= at_term ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect push-buttons; auto-repeat on RPT_MASK bits.
// Level/press lag the pin by DEBOUNCE_MS-1..DEBOUNCE_MS ms plus a few cycles; no backpressure.
module button_conditioner
   import clock_pkg::*;
#(
   parameter int               N_BTN        = clock_pkg::N_BTN,
   parameter int               CLK_HZ       = 12_000_000,
   parameter int               DEBOUNCE_MS  = 20,
   parameter int               RPT_DELAY_MS = 500,
   parameter int               RPT_RATE_MS  = 100,
   parameter logic [N_BTN-1:0] RPT_MASK     = RPT_MASK_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   button_conditioner_if.slave  bus
);

   localparam int DB_W    = $clog2(DEBOUNCE_MS + 1);
   localparam int RPT_MAX = (RPT_DELAY_MS > RPT_RATE_MS) ? RPT_DELAY_MS : RPT_RATE_MS;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic             tick;
   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;

   ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .ms_tick (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.btn;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_bit
      logic [DB_W-1:0] db_cnt;
      logic            lvl;
      logic            db_done;
      logic            rise;
      logic            fire;
      logic            prs;

      assign db_done = (db_cnt == DB_W'(DEBOUNCE_MS));
      // rise is true in the cycle before lvl first reads 1, so the registered
      // strobe and the new level appear together
      assign rise    = db_done & sync2[i] & ~lvl;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt <= '0;
            lvl    <= 1'b0;
         end else if (sync2[i] == lvl) begin
            db_cnt <= '0;
         end else if (db_done) begin
            lvl    <= sync2[i];
            db_cnt <= '0;
         end else if (tick) begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end

      if (RPT_MASK[i]) begin : g_rpt
         rpt_state_t       state;
         rpt_state_t       state_nxt;
         logic [RPT_W-1:0] cnt;
         logic [RPT_W-1:0] cnt_nxt;
         logic             fall;
         logic             rpt_fire;

         // a release that debounces in the same cycle as a repeat suppresses it
         assign fall = db_done & ~sync2[i] & lvl;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state <= RPT_IDLE;
               cnt   <= '0;
            end else begin
               state <= state_nxt;
               cnt   <= cnt_nxt;
            end
         end

         always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rpt_fire  = 1'b0;
            case (state)
               RPT_IDLE: begin
                  if (rise) begin
                     state_nxt = RPT_DELAY;
                     cnt_nxt   = '0;
                  end
               end
               RPT_DELAY: begin
                  if (fall) begin
                     state_nxt = RPT_IDLE;
                  end else if (tick) begin
                     if (cnt == RPT_W'(RPT_DELAY_MS - 1)) begin
                        rpt_fire  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = RPT_REPEAT;
                     end else begin
                        cnt_nxt = cnt + RPT_W'(1);
                     end
                  end
               end
               RPT_REPEAT: begin
                  if (fall) begin
                     state_nxt = RPT_IDLE;
                  end else if (tick) begin
                     if (cnt == RPT_W'(RPT_RATE_MS - 1)) begin
                        rpt_fire = 1'b1;
                        cnt_nxt  = '0;
                     end else begin
                        cnt_nxt = cnt + RPT_W'(1);
                     end
                  end
               end
               default: state_nxt = RPT_IDLE;
            endcase
         end

         assign fire = rpt_fire;
      end else begin : g_norpt
         assign fire = 1'b0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            prs <= 1'b0;
         end else begin
            prs <= rise | fire;
         end
      end

      assign level[i] = lvl;
      assign press[i] = prs;
   end

   assign bus.level   = level;
   assign bus.press   = press;
   assign bus.ms_tick = tick;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner at 12 cycles/ms: directed scenarios plus randomized
// glitch/hold sequences checked against a run-length model of the debounce rules.
module tb_button_conditioner;
   import clock_pkg::*;

   localparam int CLK_HZ = 12_000;
   localparam int CPM    = ms_to_cycles(CLK_HZ, 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   button_conditioner_if #(.N_BTN(N_BTN)) bus ();

   button_conditioner #(
      .N_BTN        (N_BTN),
      .CLK_HZ       (CLK_HZ),
      .DEBOUNCE_MS  (20),
      .RPT_DELAY_MS (500),
      .RPT_RATE_MS  (100),
      .RPT_MASK     (RPT_MASK_DEFAULT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Observation: strobe counts and times, level falls and rises, per button.
   int               press_cnt [N_BTN] = '{default: 0};
   int               last_press[N_BTN] = '{default: 0};
   int               last_fall [N_BTN] = '{default: 0};
   int               rise_cnt  [N_BTN] = '{default: 0};
   int               rpt_q[$];
   logic [N_BTN-1:0] lvl_prev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < N_BTN; i++) begin
         if (bus.press[i]) begin
            press_cnt[i]  = press_cnt[i] + 1;
            last_press[i] = cyc;
            if (i == BTN_VAL_INC) rpt_q.push_back(cyc);
         end
         if (lvl_prev[i] && !bus.level[i]) last_fall[i] = cyc;
         if (!lvl_prev[i] && bus.level[i]) rise_cnt[i] = rise_cnt[i] + 1;
      end
      lvl_prev = bus.level;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int  t_rel;
      int  n;
      bit  found;
      rst_n   = 1'b0;
      bus.btn = '1;
      for (int k = 0; k < 4; k++) begin
         wait_cyc(1);
         checks++;
         if ({bus.level, bus.press, bus.ms_tick} !== '0) begin
            errors++;
            $display("FAIL reset_hold: level=%h press=%h tick=%b, expected all 0",
                     bus.level, bus.press, bus.ms_tick);
         end
      end
      rst_n = 1'b1;
      t_rel = cyc;
      n = 0; found = 0;
      while (!found && n < 3 * CPM) begin
         @(posedge clk); #1; n++;
         if (bus.ms_tick) found = 1;
      end
      checks++;
      if (!found || n != CPM) begin
         errors++;
         $display("FAIL first_tick: after %0d cycles (found=%0d), expected %0d", n, found, CPM);
      end
      n = 0; found = 0;
      while (!found && n < 3 * CPM) begin
         @(posedge clk); #1; n++;
         if (bus.ms_tick) found = 1;
      end
      checks++;
      if (!found || n != CPM) begin
         errors++;
         $display("FAIL tick_period: %0d cycles (found=%0d), expected %0d", n, found, CPM);
      end
      found = 0;
      while (!found && (cyc - t_rel) < 30 * CPM) begin
         @(posedge clk); #1;
         if (bus.press !== '0) found = 1;
      end
      checks++;
      if (!found || bus.press !== '1 || bus.level !== '1) begin
         errors++;
         $display("FAIL held_press: press=%h level=%h, expected both %h", bus.press, bus.level, {N_BTN{1'b1}});
      end
      checks++;
      if ((cyc - t_rel) > 20 * CPM + 2 || (cyc - t_rel) < 19 * CPM) begin
         errors++;
         $display("FAIL held_latency: %0d cycles, expected %0d..%0d", cyc - t_rel, 19 * CPM, 20 * CPM + 2);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.press !== '0) begin
         errors++;
         $display("FAIL held_strobe_width: press=%h one cycle later, expected 0", bus.press);
      end
      bus.btn = '0;
      wait_cyc(30 * CPM);
      checks++;
      if (bus.level !== '0) begin
         errors++;
         $display("FAIL held_release: level=%h, expected 0", bus.level);
      end
   endtask

   task automatic test_single_press();
      int p0;
      int t0;
      int t1;
      p0 = press_cnt[BTN_WR];
      bus.btn[BTN_WR] = 1'b1;
      t0 = cyc;
      wait_cyc(60 * CPM);
      checks++;
      if (press_cnt[BTN_WR] - p0 != 1 || bus.level[BTN_WR] !== 1'b1) begin
         errors++;
         $display("FAIL wr_press: strobes=%0d level=%b, expected 1 and 1",
                  press_cnt[BTN_WR] - p0, bus.level[BTN_WR]);
      end
      checks++;
      if (last_press[BTN_WR] - t0 < 19 * CPM || last_press[BTN_WR] - t0 > 20 * CPM + 4) begin
         errors++;
         $display("FAIL wr_press_time: %0d cycles, expected %0d..%0d",
                  last_press[BTN_WR] - t0, 19 * CPM, 20 * CPM + 4);
      end
      bus.btn[BTN_WR] = 1'b0;
      t1 = cyc;
      wait_cyc(40 * CPM);
      checks++;
      if (bus.level[BTN_WR] !== 1'b0 || last_fall[BTN_WR] - t1 < 19 * CPM ||
          last_fall[BTN_WR] - t1 > 20 * CPM + 4) begin
         errors++;
         $display("FAIL wr_release: level=%b fall after %0d cycles, expected 0 within %0d..%0d",
                  bus.level[BTN_WR], last_fall[BTN_WR] - t1, 19 * CPM, 20 * CPM + 4);
      end
      checks++;
      if (press_cnt[BTN_WR] - p0 != 1) begin
         errors++;
         $display("FAIL wr_no_release_strobe: strobes=%0d, expected 1", press_cnt[BTN_WR] - p0);
      end
   endtask

   task automatic test_glitch();
      int p0;
      int r0;
      p0 = press_cnt[BTN_SEL_INC];
      r0 = rise_cnt[BTN_SEL_INC];
      for (int k = 0; k < 20; k++) begin
         bus.btn[BTN_SEL_INC] = 1'b1;
         wait_cyc(5 * CPM);
         bus.btn[BTN_SEL_INC] = 1'b0;
         wait_cyc(5 * CPM);
      end
      checks++;
      if (press_cnt[BTN_SEL_INC] != p0 || rise_cnt[BTN_SEL_INC] != r0 || bus.level[BTN_SEL_INC] !== 1'b0) begin
         errors++;
         $display("FAIL glitch: strobes=%0d level_rises=%0d level=%b, expected 0 0 0",
                  press_cnt[BTN_SEL_INC] - p0, rise_cnt[BTN_SEL_INC] - r0, bus.level[BTN_SEL_INC]);
      end
   endtask

   task automatic test_auto_repeat();
      int t0;
      int t1;
      int gap;
      int lo;
      rpt_q.delete();
      bus.btn[BTN_VAL_INC] = 1'b1;
      t0 = cyc;
      wait_cyc(1000 * CPM);
      bus.btn[BTN_VAL_INC] = 1'b0;
      t1 = cyc;
      wait_cyc(150 * CPM);
      checks++;
      if (rpt_q.size() != 7) begin
         errors++;
         $display("FAIL repeat_count: %0d strobes, expected 7", rpt_q.size());
      end
      if (rpt_q.size() > 0) begin
         checks++;
         if (rpt_q[0] - t0 < 19 * CPM || rpt_q[0] - t0 > 20 * CPM + 4) begin
            errors++;
            $display("FAIL repeat_first: %0d cycles, expected %0d..%0d", rpt_q[0] - t0, 19 * CPM, 20 * CPM + 4);
         end
         checks++;
         if (rpt_q[rpt_q.size() - 1] >= last_fall[BTN_VAL_INC] || last_fall[BTN_VAL_INC] < t1) begin
            errors++;
            $display("FAIL repeat_last_before_fall: last strobe %0d, level fall %0d, expected strobe first",
                     rpt_q[rpt_q.size() - 1], last_fall[BTN_VAL_INC]);
         end
      end
      for (int k = 1; k < rpt_q.size(); k++) begin
         gap = rpt_q[k] - rpt_q[k - 1];
         lo  = (k == 1) ? 500 * CPM - CPM : 100 * CPM - CPM;
         checks++;
         if (gap < lo || gap > lo + 2 * CPM) begin
            errors++;
            $display("FAIL repeat_gap%0d: %0d cycles, expected %0d..%0d", k, gap, lo, lo + 2 * CPM);
         end
      end
      checks++;
      if (bus.level[BTN_VAL_INC] !== 1'b0) begin
         errors++;
         $display("FAIL repeat_release: level=%b, expected 0", bus.level[BTN_VAL_INC]);
      end
   endtask

   task automatic test_simultaneous();
      int p3;
      int p5;
      p3 = press_cnt[BTN_VAL_DEC];
      p5 = press_cnt[BTN_SEL_DEC];
      bus.btn[BTN_VAL_DEC] = 1'b1;
      bus.btn[BTN_SEL_DEC] = 1'b1;
      wait_cyc(60 * CPM);
      bus.btn[BTN_VAL_DEC] = 1'b0;
      bus.btn[BTN_SEL_DEC] = 1'b0;
      wait_cyc(40 * CPM);
      checks++;
      if (press_cnt[BTN_VAL_DEC] - p3 != 1 || press_cnt[BTN_SEL_DEC] - p5 != 1) begin
         errors++;
         $display("FAIL simul_count: val_dec=%0d sel_dec=%0d strobes, expected 1 and 1",
                  press_cnt[BTN_VAL_DEC] - p3, press_cnt[BTN_SEL_DEC] - p5);
      end
      checks++;
      if (last_press[BTN_VAL_DEC] != last_press[BTN_SEL_DEC]) begin
         errors++;
         $display("FAIL simul_same_cycle: val_dec at %0d sel_dec at %0d, expected equal",
                  last_press[BTN_VAL_DEC], last_press[BTN_SEL_DEC]);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      int t_rel;
      p0 = press_cnt[BTN_VAL_INC];
      bus.btn[BTN_VAL_INC] = 1'b1;
      wait_cyc(600 * CPM);
      checks++;
      if (press_cnt[BTN_VAL_INC] - p0 != 2) begin
         errors++;
         $display("FAIL midrst_before: %0d strobes, expected 2", press_cnt[BTN_VAL_INC] - p0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.level, bus.press, bus.ms_tick} !== '0) begin
         errors++;
         $display("FAIL midrst_immediate: level=%h press=%h tick=%b, expected all 0",
                  bus.level, bus.press, bus.ms_tick);
      end
      wait_cyc(3);
      rst_n = 1'b1;
      t_rel = cyc;
      p0 = press_cnt[BTN_VAL_INC];
      wait_cyc(100 * CPM);
      checks++;
      if (press_cnt[BTN_VAL_INC] - p0 != 1 || last_press[BTN_VAL_INC] - t_rel < 19 * CPM ||
          last_press[BTN_VAL_INC] - t_rel > 20 * CPM + 4) begin
         errors++;
         $display("FAIL midrst_fresh_press: %0d strobes, last at %0d cycles, expected 1 within %0d..%0d",
                  press_cnt[BTN_VAL_INC] - p0, last_press[BTN_VAL_INC] - t_rel, 19 * CPM, 20 * CPM + 4);
      end
      bus.btn[BTN_VAL_INC] = 1'b0;
      wait_cyc(40 * CPM);
      checks++;
      if (bus.level !== '0) begin
         errors++;
         $display("FAIL midrst_release: level=%h, expected 0", bus.level);
      end
   endtask

   // Model: alternating runs are either clearly short (<=15 ms, never reach the
   // debounce threshold) or clearly long (>=25 ms, always settle); only long runs
   // move the level, and each long high run from a low level is one press.
   task automatic test_random_runs();
      bit model_lvl;
      bit val;
      bit is_long;
      int dur;
      int exp_press;
      int p0;
      for (int b = BTN_RESET; b <= BTN_SEL_DEC; b++) begin
         model_lvl = 1'b0;
         val       = 1'b0;
         exp_press = 0;
         p0        = press_cnt[b];
         for (int r = 0; r < 8; r++) begin
            val     = ~val;
            is_long = 1'($urandom_range(0, 1));
            dur     = is_long ? $urandom_range(25 * CPM, 40 * CPM) : $urandom_range(1, 15 * CPM);
            bus.btn[b] = val;
            wait_cyc(dur);
            if (is_long) begin
               if (val && !model_lvl) exp_press++;
               model_lvl = val;
            end
            checks++;
            if (bus.level[b] !== model_lvl) begin
               errors++;
               $display("FAIL rand_level b%0d run%0d: level=%b, expected %b (val=%b dur=%0d)",
                        b, r, bus.level[b], model_lvl, val, dur);
            end
         end
         bus.btn[b] = 1'b0;
         wait_cyc(30 * CPM);
         checks++;
         if (bus.level[b] !== 1'b0 || press_cnt[b] - p0 != exp_press) begin
            errors++;
            $display("FAIL rand_press b%0d: level=%b strobes=%0d, expected 0 and %0d",
                     b, bus.level[b], press_cnt[b] - p0, exp_press);
         end
      end
   endtask

   initial begin
      bus.btn = '0;
      test_reset();
      test_single_press();
      test_glitch();
      test_auto_repeat();
      test_simultaneous();
      test_reset_mid();
      test_random_runs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
